// File: rtl/skid_buf.sv
// skid_buf: two-entry registered valid/ready pipeline stage (skid buffer).
// Cuts both the forward (valid/data) and backward (ready) timing paths while
// sustaining one transfer per cycle.
//
// Parameters:
//   DW       data width in bits
// Ports:
//   CLK      clock, all state updates on posedge
//   RST      synchronous reset, active-high
//   FLUSH    synchronous discard of all buffered entries
//   I_VALID  upstream has data on I_DATA
//   I_READY  buffer accepts a transfer this cycle (skid register empty, low in RST)
//   I_DATA   upstream data
//   O_VALID  O_DATA holds a valid entry (registered)
//   O_READY  downstream accepts this cycle
//   O_DATA   head entry data (registered)
module skid_buf #(
    parameter int unsigned DW = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLUSH,
    input  logic          I_VALID,
    output logic          I_READY,
    input  logic [DW-1:0] I_DATA,
    output logic          O_VALID,
    input  logic          O_READY,
    output logic [DW-1:0] O_DATA
);

    // State encoding is {skid_vld, main_vld}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] main_dat_q, main_dat_d;
    logic [DW-1:0] skid_dat_q, skid_dat_d;

    logic main_vld;
    logic skid_vld;
    logic in_xfer;
    logic out_xfer;

    assign main_vld = state_q[0];
    assign skid_vld = state_q[1];

    // Ready depends only on the skid register, never on O_READY.
    assign I_READY  = !skid_vld && !RST;
    assign O_VALID  = main_vld;
    assign O_DATA   = main_dat_q;

    assign in_xfer  = I_VALID && I_READY;
    assign out_xfer = main_vld && O_READY;

    // State register; only the valid bits are reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data registers carry no reset; contents are don't-care while invalid.
    always_ff @(posedge CLK) begin
        main_dat_q <= main_dat_d;
        skid_dat_q <= skid_dat_d;
    end

    // Next-state and data-path steering.
    always_comb begin
        state_d    = state_q;
        main_dat_d = main_dat_q;
        skid_dat_d = skid_dat_q;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d    = BUSY;
                    main_dat_d = I_DATA;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_dat_d = I_DATA;
                end else if (in_xfer) begin
                    state_d    = FULL;
                    skid_dat_d = I_DATA;
                end else if (out_xfer) begin
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                // Input is blocked here; draining main promotes the skid entry.
                if (out_xfer) begin
                    state_d    = BUSY;
                    main_dat_d = skid_dat_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Handshakes in the flush cycle complete but their data is dropped.
        if (FLUSH) begin
            state_d = EMPTY;
        end
    end

`ifdef NCPU_ENABLE_ASSERT
    // Simulation-only guard against the unreachable skid-without-main state.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == 2'b10) begin
            $fatal(1, "skid_buf: unreachable state 2'b10 entered");
        end
    end

`ifdef NCPU_CHECK_X
    // Simulation-only X checks on handshake controls and accepted data.
    always_ff @(posedge CLK) begin
        if (!RST && ($isunknown(I_VALID) || $isunknown(O_READY))) begin
            $fatal(1, "skid_buf: X on I_VALID or O_READY");
        end
        if (!RST && I_VALID && I_READY && $isunknown(I_DATA)) begin
            $fatal(1, "skid_buf: X on I_DATA during input transfer");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_skid_buf.sv
// Testbench for skid_buf: directed scenarios plus a randomized run against a
// two-deep FIFO queue model.
module tb_skid_buf;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;

    int total;
    int bad;

    // Reference model: ordered queue holding at most two entries.
    logic [DW-1:0] mq[$];

    skid_buf #(.DW(DW)) dut (
        .CLK     (clk),
        .RST     (rst),
        .FLUSH   (flush),
        .I_VALID (i_valid),
        .I_READY (i_ready),
        .I_DATA  (i_data),
        .O_VALID (o_valid),
        .O_READY (o_ready),
        .O_DATA  (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, updating the model from the driven inputs only.
    task automatic tick();
        bit in_x;
        bit out_x;
        in_x  = i_valid && (mq.size() < 2) && !rst;
        out_x = o_ready && (mq.size() > 0);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back(i_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; i_data = 32'hDEAD; o_ready = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (i_ready !== 1'b0) begin
                bad++; $display("FAIL reset_i_ready cyc=%0d got=%b exp=0", i, i_ready);
            end
            total++;
            if (o_valid !== 1'b0) begin
                bad++; $display("FAIL reset_o_valid cyc=%0d got=%b exp=0", i, o_valid);
            end
            tick();
        end
        rst = 1'b0; i_valid = 1'b0;
        #1;
        total++;
        if (i_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_i_ready got=%b exp=1", i_ready);
        end
        total++;
        if (o_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_o_valid got=%b exp=0", o_valid);
        end
        tick();
    endtask

    task automatic test_streaming();
        o_ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16) begin
                i_valid = 1'b1; i_data = DW'(k);
            end else begin
                i_valid = 1'b0;
            end
            #1;
            total++;
            if (i_ready !== 1'b1) begin
                bad++; $display("FAIL stream_i_ready k=%0d got=%b exp=1", k, i_ready);
            end
            total++;
            if (k == 1) begin
                if (o_valid !== 1'b0) begin
                    bad++; $display("FAIL stream_first_o_valid got=%b exp=0", o_valid);
                end
            end else if (o_valid !== 1'b1 || o_data !== DW'(k - 1)) begin
                bad++; $display("FAIL stream_o_data k=%0d got=%b/%h exp=1/%h", k, o_valid, o_data, k - 1);
            end
            tick();
        end
        #1;
        total++;
        if (o_valid !== 1'b0) begin
            bad++; $display("FAIL stream_drained got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_backpressure();
        // cycle: 0..8 ; input data offered, O_READY, expected I_READY, O_VALID, O_DATA
        logic [DW-1:0] din [9] = '{32'hA0, 32'hA1, 32'hA2, 32'hA2, 32'hA2, 32'hA2, 32'hA2, 32'h0, 32'h0};
        bit            ivl [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        bit            ord [9] = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
        bit            erd [9] = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
        bit            evl [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [DW-1:0] edt [9] = '{32'h0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'h0};
        for (int c = 0; c < 9; c++) begin
            i_valid = ivl[c]; i_data = din[c]; o_ready = ord[c];
            #1;
            total++;
            if (i_ready !== erd[c]) begin
                bad++; $display("FAIL bp_i_ready cyc=%0d got=%b exp=%b", c, i_ready, erd[c]);
            end
            total++;
            if (o_valid !== evl[c] || (evl[c] && o_data !== edt[c])) begin
                bad++; $display("FAIL bp_out cyc=%0d got=%b/%h exp=%b/%h", c, o_valid, o_data, evl[c], edt[c]);
            end
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic test_full_drain_refill();
        logic [DW-1:0] din [7] = '{32'hB0, 32'hB1, 32'hB2, 32'hB2, 32'h0, 32'h0, 32'h0};
        bit            ivl [7] = '{1, 1, 1, 1, 0, 0, 0};
        bit            ord [7] = '{0, 0, 1, 0, 1, 1, 1};
        bit            erd [7] = '{1, 1, 0, 1, 0, 1, 1};
        bit            evl [7] = '{0, 1, 1, 1, 1, 1, 0};
        logic [DW-1:0] edt [7] = '{32'h0, 32'hB0, 32'hB0, 32'hB1, 32'hB1, 32'hB2, 32'h0};
        for (int c = 0; c < 7; c++) begin
            i_valid = ivl[c]; i_data = din[c]; o_ready = ord[c];
            #1;
            total++;
            if (i_ready !== erd[c]) begin
                bad++; $display("FAIL full_i_ready cyc=%0d got=%b exp=%b", c, i_ready, erd[c]);
            end
            total++;
            if (o_valid !== evl[c] || (evl[c] && o_data !== edt[c])) begin
                bad++; $display("FAIL full_out cyc=%0d got=%b/%h exp=%b/%h", c, o_valid, o_data, evl[c], edt[c]);
            end
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic test_flush();
        // Fill to FULL with 0x55, 0x66.
        o_ready = 1'b0;
        i_valid = 1'b1; i_data = 32'h55; tick();
        i_data = 32'h66; tick();
        i_data = 32'h77; flush = 1'b1;
        #1;
        total++;
        if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'h55) begin
            bad++; $display("FAIL flush_pre_full got=%b/%b/%h exp=0/1/55", i_ready, o_valid, o_data);
        end
        tick();
        flush = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
                bad++; $display("FAIL flush_empty cyc=%0d got=%b/%b exp=0/1", c, o_valid, i_ready);
            end
            tick();
        end
        // Flush from BUSY while an input beat is accepted: that beat is dropped.
        i_valid = 1'b1; i_data = 32'h88; o_ready = 1'b0; tick();
        i_data = 32'h99; flush = 1'b1;
        #1;
        total++;
        if (i_ready !== 1'b1 || o_data !== 32'h88) begin
            bad++; $display("FAIL flush_busy_pre got=%b/%h exp=1/88", i_ready, o_data);
        end
        tick();
        flush = 1'b0; i_valid = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            bad++; $display("FAIL flush_busy_post got=%b/%b exp=0/1", o_valid, i_ready);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            i_valid = ($urandom_range(0, 99) < 60);
            o_ready = ($urandom_range(0, 99) < 55);
            flush   = ($urandom_range(0, 99) < 1);
            i_data  = $urandom;
            #1;
            total++;
            if (i_ready !== (mq.size() < 2)) begin
                bad++; $display("FAIL rand_i_ready cyc=%0d got=%b exp=%b", c, i_ready, mq.size() < 2);
            end
            total++;
            if (o_valid !== (mq.size() > 0)) begin
                bad++; $display("FAIL rand_o_valid cyc=%0d got=%b exp=%b", c, o_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                total++;
                if (o_data !== mq[0]) begin
                    bad++; $display("FAIL rand_o_data cyc=%0d got=%h exp=%h", c, o_data, mq[0]);
                end
            end
            tick();
        end
        i_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = '0;
        @(negedge clk);
        tick();
        test_reset();
        test_streaming();
        tick();
        test_backpressure();
        test_full_drain_refill();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
